// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the shared iterative RV32M divider (DIV/DIVU/REM/REMU).
// Optional macro DIV_EARLY_OUT_EN: finish on the conditioning edge when |dividend| < |divisor|.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic              rem_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              stallreq_o
);

    // state  | meaning
    // IDLE   | waiting for start_i; operands latched on acceptance
    // BYZERO | divisor is zero; result produced on its second edge
    // ON     | first edge conditions magnitudes, then 32 restoring steps
    // END    | result_o/ready_o held until start_i drops or annul_i
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              sgn;
    logic              rem_sel;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rmd;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   trial;
    logic              fit;
    logic [DATA_W-1:0] step_q;
    logic [DATA_W-1:0] step_r;
    logic [DATA_W-1:0] q_out;
    logic [DATA_W-1:0] r_out;
    logic              early;

    assign mag1 = (sgn && op1[DATA_W-1]) ? -op1 : op1;
    assign mag2 = (sgn && op2[DATA_W-1]) ? -op2 : op2;

    // Partial remainder is always below the divisor, so one extra bit covers the shifted value.
    assign trial  = {rmd, dvd[DATA_W-1]} - {1'b0, dvs};
    assign fit    = ~trial[DATA_W];
    assign step_q = {dvd[DATA_W-2:0], fit};
    assign step_r = fit ? trial[DATA_W-1:0] : {rmd[DATA_W-2:0], dvd[DATA_W-1]};
    assign q_out  = neg_q ? -step_q : step_q;
    assign r_out  = neg_r ? -step_r : step_r;

`ifdef DIV_EARLY_OUT_EN
    assign early = (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    assign busy_o     = (state != IDLE);
    assign stallreq_o = start_i & ~ready_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op1      <= '0;
            op2      <= '0;
            sgn      <= 1'b0;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            rmd      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        op1     <= opdata1_i;
                        op2     <= opdata2_i;
                        sgn     <= signed_i;
                        rem_sel <= rem_i;
                        cnt     <= '0;
                        state   <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        cnt <= CNT_ONE;
                    end else begin
                        result_o <= rem_sel ? op1 : '1;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        dvd   <= mag1;
                        dvs   <= mag2;
                        rmd   <= '0;
                        neg_q <= sgn & (op1[DATA_W-1] ^ op2[DATA_W-1]);
                        neg_r <= sgn & op1[DATA_W-1];
                        cnt   <= cnt + CNT_ONE;
                        if (early) begin
                            result_o <= rem_sel ? op1 : '0;
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end else begin
                        dvd <= step_q;
                        rmd <= step_r;
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            result_o <= rem_sel ? r_out : q_out;
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
